// File: rtl/ibex_fetch_realigner_pkg.sv
// Shared types and helpers for the fetch realigner: the buffered fetch-word
// record and the RISC-V compressed-instruction test.
package ibex_fetch_realigner_pkg;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } fetch_entry_t;

  localparam logic [1:0] OPCODE_LSB_UNCOMP = 2'b11;

  // Any low opcode pair other than 2'b11 marks a 16-bit instruction.
  function automatic logic is_compressed(input logic [1:0] lsb);
    return (lsb != OPCODE_LSB_UNCOMP);
  endfunction

endpackage

// File: rtl/ibex_fetch_realigner_fifo.sv
// Small synchronous fetch-word FIFO with flush; exposes the two oldest entries
// so the realigner can assemble instructions that span a word boundary.
module ibex_fetch_realigner_fifo
  import ibex_fetch_realigner_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  entry_t                       push_entry,
  input  logic                         pop,
  output entry_t                       entry0,
  output entry_t                       entry1,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  entry_t          mem_r     [DEPTH];
  entry_t          shift_s   [DEPTH];
  entry_t          mem_nxt_s [DEPTH];
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_nxt_s;
  logic [CW-1:0]   wr_idx_s;

  // Shift out the head on pop, then drop the new word behind what remains.
  always_comb begin
    wr_idx_s = count_r - CW'(pop);
    for (int unsigned i = 0; i < DEPTH - 1; i++) begin
      shift_s[i] = pop ? mem_r[i + 1] : mem_r[i];
    end
    shift_s[DEPTH-1] = mem_r[DEPTH-1];
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_nxt_s[i] = (push && (CW'(i) == wr_idx_s)) ? push_entry : shift_s[i];
    end
  end

  // Occupancy update; flush discards any same-cycle push or pop.
  always_comb begin
    count_nxt_s = count_r;
    if (flush) begin
      count_nxt_s = {CW{1'b0}};
    end else begin
      count_nxt_s = count_r + CW'(push) - CW'(pop);
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      count_r <= {CW{1'b0}};
    end else begin
      mem_r   <= mem_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  assign entry0 = mem_r[0];
  assign entry1 = mem_r[1];
  assign count  = count_r;

endmodule

// File: rtl/ibex_fetch_realigner.sv
// Turns the word-aligned fetch stream into instruction slots for the compressed
// decoder, handling 16/32-bit instructions at any halfword offset, and tracks PC.
module ibex_fetch_realigner
  import ibex_fetch_realigner_pkg::*;
#(
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic [31:0] clear_addr_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_rdata_i,
  input  logic        in_err_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_rdata_o,
  output logic [31:0] out_addr_o,
  output logic        out_err_o,
  output logic        out_err_plus2_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_entry_t  w0_s, w1_s, push_entry_s;
  logic [CW-1:0] count_s;
  logic          half_r, half_nxt_s;
  logic [31:0]   pc_r, pc_nxt_s;
  logic          has1_s, has2_s, compressed_s, spanning_s;
  logic          push_s, pop_s, fire_s;
  logic [15:0]   upper_s;

  assign push_entry_s = '{data: in_rdata_i, err: in_err_i};

  ibex_fetch_realigner_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk        (clk_i),
    .rst        (rst_i),
    .flush      (clear_i),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .entry0     (w0_s),
    .entry1     (w1_s),
    .count      (count_s)
  );

  assign has1_s       = (count_s >= CW'(1));
  assign has2_s       = (count_s >= CW'(2));
  assign compressed_s = is_compressed(half_r ? w0_s.data[17:16] : w0_s.data[1:0]);
  assign spanning_s   = half_r & ~compressed_s;

  assign in_ready_o = (count_s < CW'(DEPTH));
  assign push_s     = in_valid_i & in_ready_o & ~clear_i;

  // An errored head word is always presented so the error can be taken.
  assign out_valid_o = has1_s & (~half_r | compressed_s | has2_s | w0_s.err);
  assign fire_s      = out_valid_o & out_ready_i & ~clear_i;
  assign pop_s       = fire_s & (half_r | ~compressed_s);

  assign out_addr_o      = pc_r;
  assign out_err_o       = has1_s & (w0_s.err | (spanning_s & has2_s & w1_s.err));
  assign out_err_plus2_o = has1_s & spanning_s & has2_s & ~w0_s.err & w1_s.err;

  // Slot assembly: upper half of w0 plus lower half of w1 when misaligned.
  always_comb begin
    upper_s = w1_s.data[15:0];
    if (half_r) begin
      if (compressed_s && !has2_s) begin
        upper_s = 16'h0000;
      end else begin
        upper_s = w1_s.data[15:0];
      end
      out_rdata_o = {upper_s, w0_s.data[31:16]};
    end else begin
      out_rdata_o = w0_s.data;
    end
  end

  // Halfword pointer flips only on compressed slots; PC advances by slot size.
  always_comb begin
    half_nxt_s = half_r;
    pc_nxt_s   = pc_r;
    if (clear_i) begin
      half_nxt_s = clear_addr_i[1];
      pc_nxt_s   = clear_addr_i;
    end else if (fire_s) begin
      half_nxt_s = half_r ^ compressed_s;
      pc_nxt_s   = pc_r + (compressed_s ? 32'd2 : 32'd4);
    end else begin
      half_nxt_s = half_r;
      pc_nxt_s   = pc_r;
    end
  end

  // Alignment and PC state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      half_r <= 1'b0;
      pc_r   <= BOOT_ADDR;
    end else begin
      half_r <= half_nxt_s;
      pc_r   <= pc_nxt_s;
    end
  end

endmodule

// File: tb/tb_ibex_fetch_realigner.sv
// Directed, table-driven bench for ibex_fetch_realigner (DEPTH=2, BOOT_ADDR=0x80),
// plus a hand-written fill/drain sequence.
module tb_ibex_fetch_realigner;

  logic        clk;
  logic        rst;
  logic        clear;
  logic [31:0] clear_addr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_rdata;
  logic        in_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic [31:0] out_addr;
  logic        out_err;
  logic        out_err_plus2;

  int n_checks = 0;
  int n_fail   = 0;

  ibex_fetch_realigner #(
    .DEPTH     (2),
    .BOOT_ADDR (32'h0000_0080)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .clear_i         (clear),
    .clear_addr_i    (clear_addr),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .in_rdata_i      (in_rdata),
    .in_err_i        (in_err),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_rdata_o     (out_rdata),
    .out_addr_o      (out_addr),
    .out_err_o       (out_err),
    .out_err_plus2_o (out_err_plus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs applied for one cycle; expected outputs observed during that cycle.
  typedef struct {
    logic        rst;
    logic        clr;
    logic [31:0] caddr;
    logic        iv;
    logic [31:0] idata;
    logic        ierr;
    logic        ordy;
    logic        e_irdy;
    logic        e_ov;
    logic [31:0] e_rd;
    logic [31:0] e_addr;
    logic        e_err;
    logic        e_ep2;
    logic        chk_rd;
  } vec_t;

  localparam int NV = 36;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int  pushed;
    logic full_seen;

    //            rst   clr   caddr         iv    idata         ierr  ordy  irdy  ov    rd            addr          err   ep2   chk_rd
    vecs[ 0] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000080, 1'b0, 1'b0, 1'b1};
    vecs[ 1] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 32'h00000013, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000080, 1'b0, 1'b0, 1'b0};
    vecs[ 2] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00000013, 32'h00000080, 1'b0, 1'b0, 1'b1};
    vecs[ 3] = '{1'b0, 1'b1, 32'h00000080, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000084, 1'b0, 1'b0, 1'b0};
    vecs[ 4] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 32'h45014501, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 32'h00000080, 1'b0, 1'b0, 1'b0};
    vecs[ 5] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h45014501, 32'h00000080, 1'b0, 1'b0, 1'b1};
    vecs[ 6] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00004501, 32'h00000082, 1'b0, 1'b0, 1'b1};
    vecs[ 7] = '{1'b0, 1'b1, 32'h00000080, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000084, 1'b0, 1'b0, 1'b0};
    vecs[ 8] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 32'h00134501, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000080, 1'b0, 1'b0, 1'b0};
    vecs[ 9] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00134501, 32'h00000080, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00134501, 32'h00000080, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000013, 32'h00000082, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00000013, 32'h00000082, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000000, 32'h00000086, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 32'h00000102, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00000000, 32'h00000086, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 32'h00000102, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 32'h0013AAAA, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000102, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 32'h00000102, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000013, 32'h00000102, 1'b0, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 1'b1, 32'h00000200, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000013, 32'h00000102, 1'b0, 1'b0, 1'b1};
    vecs[20] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 32'h00030001, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000200, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00030001, 32'h00000200, 1'b0, 1'b0, 1'b1};
    vecs[22] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00030001, 32'h00000200, 1'b0, 1'b0, 1'b1};
    vecs[23] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000003, 32'h00000202, 1'b1, 1'b1, 1'b1};
    vecs[24] = '{1'b0, 1'b1, 32'h00000300, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000003, 32'h00000202, 1'b1, 1'b1, 1'b1};
    vecs[25] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 32'h00030001, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000300, 1'b0, 1'b0, 1'b0};
    vecs[26] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00030001, 32'h00000300, 1'b1, 1'b0, 1'b1};
    vecs[27] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000003, 32'h00000302, 1'b1, 1'b0, 1'b1};
    vecs[28] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00000003, 32'h00000302, 1'b1, 1'b0, 1'b1};
    vecs[29] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000000, 32'h00000306, 1'b1, 1'b0, 1'b1};
    vecs[30] = '{1'b1, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000000, 32'h00000306, 1'b1, 1'b0, 1'b1};
    vecs[31] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000080, 1'b0, 1'b0, 1'b1};
    vecs[32] = '{1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000080, 1'b0, 1'b0, 1'b1};
    vecs[33] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[34] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00000000, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1};
    vecs[35] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0};

    rst        = 1'b1;
    clear      = 1'b0;
    clear_addr = 32'h0;
    in_valid   = 1'b0;
    in_rdata   = 32'h0;
    in_err     = 1'b0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst        = vecs[i].rst;
      clear      = vecs[i].clr;
      clear_addr = vecs[i].caddr;
      in_valid   = vecs[i].iv;
      in_rdata   = vecs[i].idata;
      in_err     = vecs[i].ierr;
      out_ready  = vecs[i].ordy;
      #1;
      check($sformatf("v%0d in_ready", i),       {31'h0, in_ready},      {31'h0, vecs[i].e_irdy});
      check($sformatf("v%0d out_valid", i),      {31'h0, out_valid},     {31'h0, vecs[i].e_ov});
      check($sformatf("v%0d out_addr", i),       out_addr,               vecs[i].e_addr);
      check($sformatf("v%0d out_err", i),        {31'h0, out_err},       {31'h0, vecs[i].e_err});
      check($sformatf("v%0d out_err_plus2", i),  {31'h0, out_err_plus2}, {31'h0, vecs[i].e_ep2});
      if (vecs[i].chk_rd) begin
        check($sformatf("v%0d out_rdata", i), out_rdata, vecs[i].e_rd);
      end
    end

    // Fill the FIFO with the consumer stalled, then drain one entry.
    @(negedge clk);
    rst        = 1'b0;
    clear      = 1'b1;
    clear_addr = 32'h00000400;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    @(negedge clk);
    clear     = 1'b0;
    in_valid  = 1'b1;
    in_rdata  = 32'h00000013;
    in_err    = 1'b0;
    pushed    = 0;
    full_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (!full_seen) begin
        #1;
        if (in_ready) begin
          pushed++;
          @(negedge clk);
        end else begin
          full_seen = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
    check("fill in_ready low", {31'h0, full_seen}, 32'h1);
    check("fill word count",   pushed,             32'd2);
    check("full out_valid",    {31'h0, out_valid}, 32'h1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("drain in_ready",  {31'h0, in_ready},  32'h1);
    check("drain out_addr",  out_addr,           32'h00000404);
    check("drain out_valid", {31'h0, out_valid}, 32'h1);
    check("drain out_rdata", out_rdata,          32'h00000013);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
